fetch_stage: RTL



---
 rtl/rv_pkg.sv | 11 +
 rtl/flopenrc.sv | 20 ++
 rtl/fetch_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I core constants and small helpers used by the pipeline stages.
package rv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    // Instruction fetch is word aligned, so redirect targets drop their low bits.
    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/flopenrc.sv
// Register with enable and synchronous clear; reset and clear both load INIT.
module flopenrc #(
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= INIT;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC select, and the IF/ID pipeline register feeding decode.
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
    parameter logic [XLEN-1:0] NOP      = NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pcsrc_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d,
    output logic [XLEN-1:0] fetch_count
);
    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] pcplus4_f;
    logic [XLEN-1:0] pc_next;
    logic            pc_en;
    logic            load_d;
    logic [XLEN-1:0] fetch_count_reg;

    assign pcplus4_f = pc_f + 32'd4;
    assign pc_next   = pcsrc_e ? align4(pc_target_e) : pcplus4_f;
    // A resolved redirect must land even while the hazard unit stalls fetch.
    assign pc_en     = pcsrc_e || !stall_f;
    assign imem_addr = pc_f;

    flopenrc #(.WIDTH(XLEN), .INIT(RESET_PC)) u_pc_f (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .en    (pc_en),
        .d     (pc_next),
        .q     (pc_f)
    );

    // IF/ID fields: index 0 = instruction, 1 = PC, 2 = PC+4.
    localparam logic [2:0][XLEN-1:0] IFID_INIT = {{XLEN{1'b0}}, {XLEN{1'b0}}, NOP};
    logic [2:0][XLEN-1:0] ifid_next;
    logic [2:0][XLEN-1:0] ifid_reg;

    assign ifid_next = {pcplus4_f, pc_f, imem_rdata};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ifid
            flopenrc #(.WIDTH(XLEN), .INIT(IFID_INIT[gi])) u_field (
                .clk   (clk),
                .reset (reset),
                .clear (flush_d),
                .en    (!stall_d),
                .d     (ifid_next[gi]),
                .q     (ifid_reg[gi])
            );
        end
    endgenerate

    flopenrc #(.WIDTH(1), .INIT(1'b0)) u_valid_d (
        .clk   (clk),
        .reset (reset),
        .clear (flush_d),
        .en    (!stall_d),
        .d     (1'b1),
        .q     (valid_d)
    );

    assign instr_d   = ifid_reg[0];
    assign pc_d      = ifid_reg[1];
    assign pcplus4_d = ifid_reg[2];

    // Counts exactly the edges on which IF/ID takes a real instruction.
    assign load_d = !reset && !flush_d && !stall_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_reg <= '0;
        end else if (load_d) begin
            fetch_count_reg <= fetch_count_reg + 32'd1;
        end
    end

    assign fetch_count = fetch_count_reg;
endmodule
